// File: rtl/ham_dist_ctrl_if.sv
// Operand/result handshake bundle for ham_dist_ctrl: producer side (A, B, mode)
// and consumer side (weight) with their valid/ready pairs, plus abort and status.
`timescale 1ns/1ps
interface ham_dist_ctrl_if #(
  parameter int N = 8,
  parameter int W = $clog2(N + 1)
);
  logic         in_valid;
  logic         in_ready;
  logic         mode;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         clear;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] weight;
  logic         busy;

  modport master (
    output in_valid, mode, A, B, clear, out_ready,
    input  in_ready, out_valid, weight, busy
  );

  modport slave (
    input  in_valid, mode, A, B, clear, out_ready,
    output in_ready, out_valid, weight, busy
  );
endinterface

// File: rtl/ham_dist_ctrl.sv
// Multi-cycle Hamming weight / distance engine: a BPC-bit popcount slice is
// reused every COUNT cycle while the operand shifts right through it.
`timescale 1ns/1ps
module ham_dist_ctrl #(
  parameter int N          = 8,
  parameter int BPC        = 2,
  parameter int EARLY_EXIT = 1
) (
  input logic            clk,
  input logic            rst,
  ham_dist_ctrl_if.slave bus
);
  localparam int W      = $clog2(N + 1);
  localparam int SLICES = N / BPC;
  localparam int CW     = (SLICES > 1) ? $clog2(SLICES) : 1;

  generate
    if ((N < 2) || (BPC < 1) || ((N % BPC) != 0)) begin : g_bad_params
      $error("ham_dist_ctrl: N must be >= 2 and a multiple of BPC");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   shreg_q, shreg_d;
  logic [W-1:0]   acc_q, acc_d;
  logic [W-1:0]   weight_q, weight_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  logic [W-1:0]   acc_sum;
  logic [N-1:0]   shreg_nxt;
  logic           last_slice;

  function automatic logic [W-1:0] popcount_slice(input logic [BPC-1:0] s);
    logic [W-1:0] c;
    c = '0;
    for (int i = 0; i < BPC; i++) begin
      c = c + W'(s[i]);
    end
    return c;
  endfunction

  // The slice just counted is the last one either by position or, with early
  // exit, because nothing set remains above it.
  always_comb begin
    acc_sum    = acc_q + popcount_slice(shreg_q[BPC-1:0]);
    shreg_nxt  = shreg_q >> BPC;
    last_slice = (cnt_q == CW'(SLICES - 1)) ||
                 ((EARLY_EXIT != 0) && (shreg_nxt == '0));
  end

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    weight_d = weight_q;
    unique case (state_q)
      IDLE: begin
        if (!bus.clear && bus.in_valid) begin
          shreg_d = bus.mode ? (bus.A ^ bus.B) : bus.A;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = COUNT;
        end
      end
      COUNT: begin
        if (bus.clear) begin
          state_d = IDLE;
        end else begin
          acc_d   = acc_sum;
          shreg_d = shreg_nxt;
          cnt_d   = cnt_q + CW'(1);
          if (last_slice) begin
            weight_d = acc_sum;
            state_d  = DONE;
          end
        end
      end
      DONE: begin
        if (bus.clear || bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      weight_q <= '0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      weight_q <= weight_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.weight    = weight_q;
endmodule
